// File: rtl/seq_eac_adder_if.sv
// Operand/result bundle for the segmented end-around-carry adder.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
// the producer holds its data stable from raising valid until that edge; ready may not depend on valid.
interface seq_eac_adder_if #(
    parameter int ADDER_WIDTH = 64
);
    logic                   in_valid;
    logic                   in_ready;
    logic [ADDER_WIDTH-1:0] in1;
    logic [ADDER_WIDTH-1:0] in2;
    logic                   cin;
    logic                   sticky;
    logic                   eff_sub;
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDER_WIDTH-1:0] sum;
    logic                   cout;
    logic                   eac_applied;

    modport master (
        output in_valid, in1, in2, cin, sticky, eff_sub, out_ready,
        input  in_ready, out_valid, sum, cout, eac_applied
    );

    modport slave (
        input  in_valid, in1, in2, cin, sticky, eff_sub, out_ready,
        output in_ready, out_valid, sum, cout, eac_applied
    );
endinterface

// File: rtl/seq_eac_adder.sv
// Segmented sequential adder: one SEG_WIDTH slice per cycle, then an optional
// end-around-carry increment pass that stops as soon as the carry dies out.
module seq_eac_adder #(
    parameter int ADDER_WIDTH = 64,
    parameter int SEG_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_eac_adder_if.slave      bus,
    output logic [1:0]          fsm_state
);
    localparam int N_SEG     = ADDER_WIDTH / SEG_WIDTH;
    localparam int SEG_IDX_W = $clog2(N_SEG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                          state;
    logic [SEG_IDX_W-1:0]            seg;
    logic                            carry;
    logic [N_SEG-1:0][SEG_WIDTH-1:0] a_q;
    logic [N_SEG-1:0][SEG_WIDTH-1:0] b_q;
    logic [N_SEG-1:0][SEG_WIDTH-1:0] sum_q;
    logic                            sticky_q;
    logic                            eff_sub_q;
    logic                            cout_q;
    logic                            eac_q;
    logic                            in_ready_q;
    logic                            out_valid_q;

    logic [SEG_WIDTH-1:0] op_a;
    logic [SEG_WIDTH-1:0] op_b;
    logic [SEG_WIDTH:0]   seg_add;
    logic                 last_seg;

    // PASS2 reuses the same slice adder to ripple the increment through the stored sum.
    always_comb begin
        op_a = a_q[seg];
        op_b = b_q[seg];
        if (state == PASS2) begin
            op_a = sum_q[seg];
            op_b = '0;
        end
        seg_add  = {1'b0, op_a} + {1'b0, op_b} + {{SEG_WIDTH{1'b0}}, carry};
        last_seg = (seg == SEG_IDX_W'(N_SEG - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            seg         <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            sticky_q    <= 1'b0;
            eff_sub_q   <= 1'b0;
            cout_q      <= 1'b0;
            eac_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.in1;
                        b_q        <= bus.in2;
                        carry      <= bus.cin;
                        sticky_q   <= bus.sticky;
                        eff_sub_q  <= bus.eff_sub;
                        seg        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= PASS1;
                    end
                end
                PASS1: begin
                    sum_q[seg] <= seg_add[SEG_WIDTH-1:0];
                    carry      <= seg_add[SEG_WIDTH];
                    if (last_seg) begin
                        cout_q <= seg_add[SEG_WIDTH];
                        seg    <= '0;
                        if (eff_sub_q && !sticky_q && seg_add[SEG_WIDTH]) begin
                            carry <= 1'b1;
                            state <= PASS2;
                        end else begin
                            eac_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end else begin
                        seg <= seg + SEG_IDX_W'(1);
                    end
                end
                PASS2: begin
                    sum_q[seg] <= seg_add[SEG_WIDTH-1:0];
                    carry      <= seg_add[SEG_WIDTH];
                    // Carry out of the top slice is dropped: the result wraps.
                    if (!seg_add[SEG_WIDTH] || last_seg) begin
                        eac_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        seg <= seg + SEG_IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.sum         = sum_q;
    assign bus.cout        = cout_q;
    assign bus.eac_applied = eac_q;
    assign fsm_state       = state;
endmodule

// File: doc/seq_eac_adder.md
SEQ_EAC_ADDER -- requirements
Module: seq_eac_adder

Interface
REQ-001 Parameter: ADDER_WIDTH, default 64, operand/result width in bits.
REQ-002 Parameter: SEG_WIDTH, default 16, bits added per cycle; N_SEG = ADDER_WIDTH/SEG_WIDTH; ADDER_WIDTH SHALL be an integer multiple of SEG_WIDTH, N_SEG >= 2.
REQ-003 Clocking and reset SHALL be as follows: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 in1, in2  input  ADDER_WIDTH  operands; in2 is already one's-complemented by the caller for effective subtraction.
REQ-009 cin  input  1  carry into bit 0.
REQ-010 sticky  input  1  sticky bit; suppresses end-around carry when 1.
REQ-011 eff_sub  input  1  1 = effective subtraction (end-around carry enabled), 0 = addition.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  ADDER_WIDTH  result.
REQ-015 cout  output  1  carry out of bit ADDER_WIDTH-1 of first pass.
REQ-016 eac_applied  output  1  end-around increment was performed.

Function
REQ-017 States SHALL be IDLE, PASS1, PASS2, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-018 In IDLE, in_valid=1 at a rising edge SHALL latch in1, in2, cin, sticky, eff_sub, set seg index=0, carry=cin, and enter PASS1.
REQ-019 Each PASS1 edge SHALL add segment seg of in1 and in2 plus carry, write segment seg of sum, store its carry-out, and increment seg.
REQ-020 After segment N_SEG-1 in PASS1, cout SHALL take the final carry; if eff_sub=1, sticky=0 and cout=1, the block SHALL enter PASS2 with seg=0, carry=1; otherwise it SHALL enter DONE with eac_applied=0.
REQ-021 Each PASS2 edge SHALL add carry to sum segment seg and rewrite it; if the segment carry-out is 0 or seg==N_SEG-1, the block SHALL enter DONE with eac_applied=1, else increment seg.
REQ-022 The PASS2 final carry-out SHALL be discarded; sum wraps modulo 2^ADDER_WIDTH.
REQ-023 Result: sum = (in1+in2+cin+eac) mod 2^ADDER_WIDTH, where eac = eff_sub & ~sticky & cout.
REQ-024 Latency from accepting edge to first out_valid=1 cycle SHALL be N_SEG cycles without EAC, N_SEG+m with EAC, where m = 1 + number of consecutive all-ones low-order sum segments after PASS1, capped at N_SEG.
REQ-025 In DONE, sum, cout, eac_applied SHALL remain stable until out_ready=1 at a rising edge, which SHALL return to IDLE.
REQ-026 in_ready SHALL be 0 in PASS1, PASS2, DONE; in_valid in those states SHALL be ignored and operands not sampled.
REQ-027 Latched operands SHALL not change while not in IDLE regardless of input activity.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, seg=0, sum=0, cout=0, eac_applied=0, out_valid=0, in_ready=1; no capture while rst_n low.
REQ-029 Reset during PASS1, PASS2 or DONE SHALL abort the operation; no result SHALL be presented after release.

Verification (ADDER_WIDTH=64, SEG_WIDTH=16)
REQ-030 in1=5, in2=3, cin=0, eff_sub=0 -> sum=8, cout=0, eac_applied=0, out_valid 4 cycles after accept.
REQ-031 in1=5, in2=0xFFFF_FFFF_FFFF_FFFC, cin=0, eff_sub=1, sticky=0 -> sum=2, cout=1, eac_applied=1, latency 5.
REQ-032 Same as REQ-031 with sticky=1 -> sum=1, cout=1, eac_applied=0, latency 4.
REQ-033 in1=in2=0xFFFF_FFFF_FFFF_FFFF, cin=1, eff_sub=1, sticky=0 -> sum=0, cout=1, eac_applied=1, latency 8.
REQ-034 out_ready held 0 for 3 cycles in DONE -> sum/cout/eac_applied stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 rst_n pulsed low in cycle 2 of PASS1 -> out_valid=0, in_ready=1, sum=0 immediately; subsequent operand set completes correctly.
